// File: rtl/stream_mux2_pkg.sv
// Shared types and constants for the two-input round-robin stream mux.
package stream_mux2_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  // Source tag values carried on out_sel and held in last_grant.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/stream_mux2_rr_if.sv
// Handshake bundle for the two input streams and the registered output stream.
interface stream_mux2_rr_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_last;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_last;
  logic             b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  // Environment side: drives sources and downstream ready.
  modport master (
    output a_data, a_valid, a_last,
    input  a_ready,
    output b_data, b_valid, b_last,
    input  b_ready,
    input  out_data, out_sel, out_last, out_valid,
    output out_ready
  );

  // Mux side.
  modport slave (
    input  a_data, a_valid, a_last,
    output a_ready,
    input  b_data, b_valid, b_last,
    output b_ready,
    output out_data, out_sel, out_last, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/stream_mux2_rr_arb2.sv
// Combinational grant logic: packet lock first, otherwise round-robin on ties.
module rr_arb2
  import stream_mux2_pkg::*;
(
  input  state_e state_i,
  input  logic   last_grant_i,
  input  logic   a_valid_i,
  input  logic   b_valid_i,
  output logic   grant_a_o,
  output logic   grant_b_o
);

  always_comb begin
    grant_a_o = 1'b0;
    grant_b_o = 1'b0;
    unique case (state_i)
      IDLE: begin
        // Tie goes to whichever source did not finish the previous packet.
        if (a_valid_i && b_valid_i) begin
          grant_a_o = (last_grant_i == SEL_B);
          grant_b_o = (last_grant_i == SEL_A);
        end else begin
          grant_a_o = a_valid_i;
          grant_b_o = b_valid_i;
        end
      end
      LOCK_A:  grant_a_o = 1'b1;
      LOCK_B:  grant_b_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/stream_mux2_rr.sv
// Packet-aware round-robin 2:1 stream mux with a one-entry registered output stage.
module stream_mux2_rr
  import stream_mux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux2_rr_if.slave bus
);

  state_e           state_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q;

  logic grant_a, grant_b;
  logic can_load, a_fire, b_fire, fire;

  rr_arb2 u_arb (
    .state_i      (state_q),
    .last_grant_i (last_grant_q),
    .a_valid_i    (bus.a_valid),
    .b_valid_i    (bus.b_valid),
    .grant_a_o    (grant_a),
    .grant_b_o    (grant_b)
  );

  // Output slot is free when empty or being drained this cycle.
  assign can_load    = !out_valid_q || bus.out_ready;
  assign bus.a_ready = grant_a && can_load;
  assign bus.b_ready = grant_b && can_load;
  assign a_fire      = bus.a_valid && bus.a_ready;
  assign b_fire      = bus.b_valid && bus.b_ready;
  assign fire        = a_fire || b_fire;

  always_comb begin
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    out_last_d = out_last_q;
    if (a_fire) begin
      out_data_d = bus.a_data;
      out_sel_d  = SEL_A;
      out_last_d = bus.a_last;
    end else if (b_fire) begin
      out_data_d = bus.b_data;
      out_sel_d  = SEL_B;
      out_last_d = bus.b_last;
    end
  end

  // Output register: load on fire, otherwise empty once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= SEL_B;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (fire) begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Packet lock FSM; last_grant moves only when a packet ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_B;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (a_fire) begin
            if (bus.a_last) last_grant_q <= SEL_A;
            else            state_q      <= LOCK_A;
          end else if (b_fire) begin
            if (bus.b_last) last_grant_q <= SEL_B;
            else            state_q      <= LOCK_B;
          end
        end
        LOCK_A: begin
          if (a_fire && bus.a_last) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_A;
          end
        end
        LOCK_B: begin
          if (b_fire && bus.b_last) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_B;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux2_rr.sv
// Scoreboard bench for stream_mux2_rr: a reference arbiter predicts readies and output beats.
module tb_stream_mux2_rr;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux2_rr_if #(.WIDTH(W)) bus ();

  stream_mux2_rr #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = idle, 1 = locked on A, 2 = locked on B; m_lg 1 = A last.
  int   m_state;
  logic m_lg;
  logic m_ov;
  logic [W+1:0] sbq[$];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_lg    = 1'b0;
    m_ov    = 1'b0;
    sbq.delete();
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ad, input logic al,
                       input logic bv, input logic [W-1:0] bd, input logic bl,
                       input logic ordy);
    bus.a_valid = av; bus.a_data = ad; bus.a_last = al;
    bus.b_valid = bv; bus.b_data = bd; bus.b_last = bl;
    bus.out_ready = ordy;
  endtask

  // One clock: check readies/output against the model, then advance model and clock.
  task automatic cycle();
    logic ga, gb, can, af, bf;
    logic [W+1:0] exp;
    #1;
    can = !m_ov || bus.out_ready;
    ga = 1'b0;
    gb = 1'b0;
    case (m_state)
      0: begin
        ga = bus.a_valid && (!bus.b_valid || !m_lg);
        gb = bus.b_valid && (!bus.a_valid || m_lg);
      end
      1: ga = 1'b1;
      default: gb = 1'b1;
    endcase
    check_eq("a_ready", 8'(bus.a_ready), 8'(ga && can));
    check_eq("b_ready", 8'(bus.b_ready), 8'(gb && can));
    check_eq("out_valid", 8'(bus.out_valid), 8'(m_ov));
    if (m_ov) begin
      if (sbq.size() == 0) begin
        check_eq("sb_underflow", 8'(1), 8'(0));
      end else begin
        exp = sbq[0];
        check_eq("out_beat", 8'({bus.out_data, bus.out_sel, bus.out_last}), 8'(exp));
        if (bus.out_ready) void'(sbq.pop_front());
      end
    end
    af = bus.a_valid && ga && can;
    bf = bus.b_valid && gb && can;
    if (af) begin
      sbq.push_back({bus.a_data, 1'b1, bus.a_last});
      if (bus.a_last) begin m_state = 0; m_lg = 1'b1; end
      else            m_state = 1;
    end else if (bf) begin
      sbq.push_back({bus.b_data, 1'b0, bus.b_last});
      if (bus.b_last) begin m_state = 0; m_lg = 1'b0; end
      else            m_state = 2;
    end
    if (af || bf)            m_ov = 1'b1;
    else if (bus.out_ready)  m_ov = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] xz_pat;

  initial begin
    drive(0, '0, 0, 0, '0, 0, 1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_out_valid", 8'(bus.out_valid), 8'(0));
    check_eq("rst_out_data", 8'(bus.out_data), 8'(0));
    check_eq("rst_out_sel", 8'(bus.out_sel), 8'(0));
    check_eq("rst_out_last", 8'(bus.out_last), 8'(0));
    @(negedge clk);

    // Single-beat A packet.
    drive(1, 4'b0101, 1, 0, '0, 0, 1);
    cycle();
    drive(0, '0, 0, 0, '0, 0, 1);
    cycle();

    // Both valid, single-beat packets: alternation starting with A after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'd5, 1, 1, 4'd4, 1, 1);
      cycle();
    end
    drive(0, '0, 0, 0, '0, 0, 1);
    cycle();

    // 3-beat A packet holds off a waiting B.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1, W'(k), (k == 3), 1, 4'd9, 1, 1);
      cycle();
    end
    drive(0, '0, 0, 1, 4'd9, 1, 1);
    cycle();
    drive(0, '0, 0, 0, '0, 0, 1);
    cycle();
    cycle();

    // Backpressure for 4 cycles, then simultaneous drain and load.
    drive(1, 4'd7, 1, 0, '0, 0, 1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'd8, 1, 1, 4'd3, 1, 0);
      cycle();
    end
    drive(1, 4'd8, 1, 1, 4'd3, 1, 1);
    cycle();
    drive(0, '0, 0, 0, '0, 0, 1);
    cycle();
    cycle();

    // Unknown/high-impedance payload bits pass straight through.
    xz_pat = 4'bxz1x;
    drive(0, '0, 0, 1, xz_pat, 1, 1);
    cycle();
    drive(0, '0, 0, 0, '0, 0, 1);
    cycle();

    // Reset in the middle of an A packet.
    drive(1, 4'd1, 0, 0, '0, 0, 1);
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 8'(bus.out_valid), 8'(0));
    check_eq("midrst_out_data", 8'(bus.out_data), 8'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, '0, 0, 1, 4'd6, 1, 1);
    cycle();
    drive(0, '0, 0, 0, '0, 0, 1);
    cycle();

    // Random traffic with bubbles and backpressure.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) != 0));
      cycle();
    end

    // Finish any open packet, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'd2, 1, 1, 4'd3, 1, 1);
      cycle();
    end
    drive(0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("sb_drained", 8'(sbq.size()), 8'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux2_rr.md
Name: stream_mux2_rr

Overview:
- Two-input, packet-aware, round-robin stream multiplexer with valid/ready handshakes and a registered output stage.
- Sits directly upstream of the 4-bit 2:1 select mux datapath. It generates the select (sel=1 means source A) and presents registered data.
- Once a packet from one source has started, that source keeps the grant until its last beat has been accepted.

Parameters:
- WIDTH, 4: data width of each input and of the output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_data  input  WIDTH  source A payload.
- a_valid  input  1  source A beat offered.
- a_last  input  1  final beat of the source A packet.
- a_ready  output  1  source A beat accepted this cycle.
- b_data  input  WIDTH  source B payload.
- b_valid  input  1  source B beat offered.
- b_last  input  1  final beat of the source B packet.
- b_ready  output  1  source B beat accepted this cycle.
- out_data  output  WIDTH  registered payload.
- out_sel  output  1  registered source tag: 1 = A, 0 = B.
- out_last  output  1  registered last flag.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the output beat.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, out_last=0, state=IDLE, last_grant=B, so A wins the first tie.
- Output register is one entry. can_load = !out_valid | out_ready (combinational).
- Input ready is combinational: a_ready = grant_a & can_load; b_ready = grant_b & can_load. grant_a and grant_b are never both 1.
- Transfer fires when x_valid & x_ready. On the same edge: out_data<=x_data, out_sel<=(x==A), out_last<=x_last, out_valid<=1.
- If out_valid & out_ready and no input fires: out_valid<=0. Data, sel and last hold their previous values.
- Latency: 1 cycle from input fire to out_valid. Full throughput of 1 beat/cycle while out_ready=1.
- States:
  - IDLE: if only one source is valid, grant it. If both are valid, grant the source != last_grant. If neither is valid, no grant.
  - LOCK_A: grant A only; b_ready=0 regardless of b_valid.
  - LOCK_B: the mirror of LOCK_A.
- Transitions:
  - IDLE, fire with last=0 -> LOCK_x.
  - IDLE, fire with last=1 -> stays IDLE; last_grant<=x.
  - LOCK_x, fire with last=1 -> IDLE; last_grant<=x.
  - LOCK_x, any other cycle -> stays LOCK_x, including while x_valid=0 (bubbles).
  - last_grant updates only at packet end, never mid-packet.
- Boundary conditions:
  - Backpressure (out_valid=1, out_ready=0): both readies are 0; the output holds stable; state holds.
  - Simultaneous drain and load in the same cycle is allowed; out_valid stays 1.
  - A source dropping valid in IDLE before it fires may be overtaken by the other source; no error.
  - Input data containing x/z bits is passed through unmodified. The bench compares with ===.
  - Reset mid-packet: the packet is abandoned; the output beat is discarded; state returns to IDLE.
- Invariants: out_data changes only on a fire or on reset. No combinational path from a_data or b_data to outputs.

Decomposition:
- Package stream_mux2_pkg holds:
  - state enum {IDLE, LOCK_A, LOCK_B}.
  - constants SEL_A=1'b1 and SEL_B=1'b0.
- Sub-module rr_arb2: purely combinational. Inputs: state, last_grant, a_valid, b_valid. Outputs: grant_a, grant_b.
- Top level holds the state register, the last_grant register and the output register.

Test Plan:
- Reset, then a_valid=1, a_data=4'b0101, a_last=1, out_ready=1 -> a_ready=1; next cycle out_valid=1, out_data=0101, out_sel=1, out_last=1.
- Both valid every cycle, single-beat packets, a_data=5, b_data=4, out_ready=1 -> out_sel sequence 1,0,1,0; out_data 5,4,5,4.
- A 3-beat packet (data 1,2,3, last on 3) with b_valid=1 throughout -> b_ready=0 until A's last fires; B's first beat appears on the cycle after out_data=3.
- out_valid=1, out_ready=0 held for 4 cycles -> a_ready=b_ready=0; out_data unchanged; on out_ready=1 the next beat loads in the same cycle.
- b_data=4'bxz1x, b_last=1, a_valid=0 -> out_data===4'bxz1x, out_sel=0.
- rst_n pulsed low mid-way through an A packet -> out_valid drops immediately; state is IDLE; the next B beat is granted without waiting for a_last.
